// File: rtl/exec_unit_mc.sv
// exec_unit_mc -- execute-stage unit between ID/EX and EX/MEM.
//
// Decodes ALUOp_i plus {funct7,funct3} into an internal operation and runs
// it on XLEN-bit operands. Single-cycle ops come back registered one cycle
// after acceptance. mul runs on an iterative shift-add multiplier consuming
// MUL_BPC multiplier bits per cycle and holds ready_o low while busy.
//
// Parameters:
//   XLEN     operand/result width (power of two, >= 8)
//   MUL_BPC  multiplier bits per cycle (1, 2 or 4; must divide XLEN)
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i               operation request (accepted when ready_o = 1)
//   ALUOp_i [1:0]         00 ld/st (add), 01 I-type, 10 R-type, 11 branch (sub)
//   funct_i [9:0]         {funct7, funct3}
//   src1_i, src2_i        operands (src2 = immediate for I-type)
//   ready_o               unit can accept a request this cycle
//   valid_o               one-cycle pulse, result_o valid
//   result_o              registered result
//   zero_o                result_o == 0
//   illegal_o             pulses with valid_o on an undecodable funct
module exec_unit_mc #(
    parameter int XLEN    = 32,
    parameter int MUL_BPC = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int SHW    = $clog2(XLEN);
    localparam int N_ITER = XLEN / MUL_BPC;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_MUL, OP_ILL
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    op_e             op;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] partial;
    logic [XLEN-1:0] acc_next;
    logic [SHW-1:0]  shamt;

    // ---------------- decode ----------------
    always_comb begin
        op = OP_ILL;
        case (ALUOp_i)
            2'b00: op = OP_ADD;
            2'b11: op = OP_SUB;
            2'b10: begin
                case (funct_i)
                    10'b0000000_111: op = OP_AND;
                    10'b0000000_110: op = OP_OR;
                    10'b0000000_100: op = OP_XOR;
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000000_001: op = OP_SLL;
                    10'b0000000_101: op = OP_SRL;
                    10'b0100000_101: op = OP_SRA;
                    10'b0000000_010: op = OP_SLT;
                    10'b0000001_000: op = OP_MUL;
                    default:         op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: upper funct bits are immediate, only funct7[5]
                // (funct_i[8]) matters, to pick srai over srli.
                case (funct_i[2:0])
                    3'b000:  op = OP_ADD;
                    3'b111:  op = OP_AND;
                    3'b110:  op = OP_OR;
                    3'b100:  op = OP_XOR;
                    3'b010:  op = OP_SLT;
                    3'b001:  op = OP_SLL;
                    3'b101:  op = funct_i[8] ? OP_SRA : OP_SRL;
                    default: op = OP_ILL;
                endcase
            end
        endcase
    end

    // ---------------- single-cycle datapath ----------------
    assign shamt   = src2_i[SHW-1:0];
    assign sra_res = $unsigned($signed(src1_i) >>> shamt);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_XOR:  alu_res = src1_i ^ src2_i;
            OP_SLL:  alu_res = src1_i << shamt;
            OP_SRL:  alu_res = src1_i >> shamt;
            OP_SRA:  alu_res = sra_res;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_res = '0;  // illegal (mul never takes this path)
        endcase
    end

    // ---------------- shift-add multiplier step ----------------
    // One step adds mcand * mplier[MUL_BPC-1:0]; the product is built from
    // shifted copies of mcand so no hard multiplier is inferred.
    always_comb begin
        partial = '0;
        for (int b = 0; b < MUL_BPC; b++) begin
            if (mplier_q[b]) partial = partial + (mcand_q << b);
        end
        acc_next = acc_q + partial;
    end

    // ---------------- FSM / next state ----------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        valid_d  = 1'b0;
        ill_d    = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = src1_i;
                        mplier_d = src2_i;
                        cnt_d    = CNT_W'(N_ITER);
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        valid_d  = 1'b1;
                        ill_d    = (op == OP_ILL);
                    end
                end
            end
            default: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << MUL_BPC;
                mplier_d = mplier_q >> MUL_BPC;
                cnt_d    = cnt_q - 1'b1;
                // Last step: publish acc_next directly so the result lands on
                // the same edge as the final accumulation.
                if (cnt_q == CNT_W'(1)) begin
                    result_d = acc_next;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
            ill_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ill_q    <= ill_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = (result_q == '0);
    assign illegal_o = ill_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
module tb_exec_unit_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [1:0]  aluop;
    logic [9:0]  funct;
    logic [31:0] s1, s2;

    logic        rdy1, vld1, zero1, ill1;
    logic [31:0] res1;
    logic        rdy4, vld4, zero4, ill4;
    logic [31:0] res4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_unit_mc #(.XLEN(32), .MUL_BPC(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop),
        .funct_i(funct), .src1_i(s1), .src2_i(s2),
        .ready_o(rdy1), .valid_o(vld1), .result_o(res1),
        .zero_o(zero1), .illegal_o(ill1)
    );

    exec_unit_mc #(.XLEN(32), .MUL_BPC(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(aluop),
        .funct_i(funct), .src1_i(s1), .src2_i(s2),
        .ready_o(rdy4), .valid_o(vld4), .result_o(res4),
        .zero_o(zero4), .illegal_o(ill4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [9:0] f,
                         input logic [31:0] x, input logic [31:0] y);
        valid = v; aluop = a; funct = f; s1 = x; s2 = y;
    endtask

    initial begin
        int lo1, lo4, vc1, vc4, k1, k4;
        logic [31:0] r1, r4;

        // ---- reset with a request pending ----
        rst = 1'b1;
        drive(1'b1, 2'b00, 10'd0, 32'd3, 32'd4);
        tick(); tick();
        chk("rst_ready", {31'd0, rdy1}, 32'd1);
        chk("rst_valid", {31'd0, vld1}, 32'd0);
        chk("rst_result", res1, 32'd0);
        chk("rst_zero", {31'd0, zero1}, 32'd1);
        chk("rst_ill", {31'd0, ill1}, 32'd0);
        rst = 1'b0;

        // ---- R-type stream, one op per cycle ----
        drive(1'b1, 2'b10, 10'b0000000_000, 32'd5, 32'd7);                   // add
        tick();
        chk("add_valid", {31'd0, vld1}, 32'd1);
        chk("add_res", res1, 32'h0000000C);
        drive(1'b1, 2'b10, 10'b0100000_000, 32'd5, 32'd7);                   // sub
        tick();
        chk("sub_valid", {31'd0, vld1}, 32'd1);
        chk("sub_res", res1, 32'hFFFFFFFE);
        drive(1'b1, 2'b10, 10'b0000000_010, 32'hFFFFFFFF, 32'd1);            // slt
        tick();
        chk("slt_valid", {31'd0, vld1}, 32'd1);
        chk("slt_res", res1, 32'd1);
        drive(1'b1, 2'b10, 10'b0000000_001, 32'd1, 32'd35);                  // sll
        tick();
        chk("sll_valid", {31'd0, vld1}, 32'd1);
        chk("sll_res", res1, 32'h00000008);
        chk("sll_res_bpc4", res4, 32'h00000008);
        drive(1'b0, 2'b10, 10'b0000000_000, 32'd0, 32'd0);
        tick();
        chk("idle_valid", {31'd0, vld1}, 32'd0);
        chk("hold_res", res1, 32'h00000008);

        // ---- I-type shifts ----
        drive(1'b1, 2'b01, 10'b0100000_101, 32'h80000000, 32'd4);            // srai
        tick();
        chk("srai_res", res1, 32'hF8000000);
        drive(1'b1, 2'b01, 10'b0000000_101, 32'h80000000, 32'd4);            // srli
        tick();
        chk("srli_res", res1, 32'h08000000);
        drive(1'b1, 2'b01, 10'b0000000_011, 32'd1, 32'd2);                   // funct3 011
        tick();
        chk("itype_ill", {31'd0, ill1}, 32'd1);
        chk("itype_ill_res", res1, 32'd0);

        // ---- illegal R-type, branch compare, load/store add ----
        drive(1'b1, 2'b10, 10'b1111111_000, 32'd9, 32'd9);
        tick();
        chk("ill_flag", {31'd0, ill1}, 32'd1);
        chk("ill_valid", {31'd0, vld1}, 32'd1);
        chk("ill_res", res1, 32'd0);
        drive(1'b1, 2'b11, 10'b0000000_000, 32'h1234, 32'h1234);
        tick();
        chk("br_zero", {31'd0, zero1}, 32'd1);
        chk("br_res", res1, 32'd0);
        chk("br_ill", {31'd0, ill1}, 32'd0);
        drive(1'b1, 2'b00, 10'b1111111_111, 32'h10, 32'h20);
        tick();
        chk("ldst_res", res1, 32'h30);
        chk("ldst_zero", {31'd0, zero1}, 32'd0);
        chk("ldst_ill", {31'd0, ill1}, 32'd0);
        drive(1'b0, 2'b00, 10'd0, 32'd0, 32'd0);
        tick();

        // ---- mul 0xFFFFFFFF x 3 on both instances ----
        drive(1'b1, 2'b10, 10'b0000001_000, 32'hFFFFFFFF, 32'd3);
        tick();                                                              // accept edge T
        drive(1'b1, 2'b10, 10'b0000000_000, 32'd1, 32'd1);                   // add while busy
        lo1 = 0; lo4 = 0; vc1 = 0; vc4 = 0; k1 = -1; k4 = -1; r1 = '0; r4 = '0;
        for (int k = 0; k < 40; k++) begin
            if (!rdy1) lo1++;
            if (!rdy4) lo4++;
            if (vld1) begin vc1++; k1 = k; r1 = res1; end
            if (vld4) begin vc4++; k4 = k; r4 = res4; end
            if (k == 2) valid = 1'b0;
            tick();
        end
        chk("mul1_busy", lo1, 32'd32);
        chk("mul1_at", k1, 32'd32);
        chk("mul1_pulses", vc1, 32'd1);
        chk("mul1_res", r1, 32'hFFFFFFFD);
        chk("mul4_busy", lo4, 32'd8);
        chk("mul4_at", k4, 32'd8);
        chk("mul4_pulses", vc4, 32'd1);
        chk("mul4_res", r4, 32'hFFFFFFFD);

        // ---- reset 10 cycles into a mul ----
        drive(1'b1, 2'b10, 10'b0000001_000, 32'd6, 32'd7);
        tick();                                                              // accept edge T
        valid = 1'b0;
        vc1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (vld1) vc1++;
            if (k == 9) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("rstmul_ready1", {31'd0, rdy1}, 32'd1);
        chk("rstmul_ready4", {31'd0, rdy4}, 32'd1);
        for (int k = 0; k < 35; k++) begin
            if (vld1) vc1++;
            tick();
        end
        chk("rstmul_no_valid", vc1, 32'd0);
        drive(1'b1, 2'b10, 10'b0000000_000, 32'd1, 32'd1);
        tick();
        valid = 1'b0;
        chk("post_rst_add_valid", {31'd0, vld1}, 32'd1);
        chk("post_rst_add", res1, 32'd2);
        chk("post_rst_add_bpc4", res4, 32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit_mc.md
# exec_unit_mc

Parametrised execute-stage unit for the RISC-V core: decodes `ALUOp_i` and the `{funct7,funct3}` field into an internal ALU operation and executes it on `XLEN`-bit operands. Single-cycle ops return a registered result one cycle after acceptance. `mul` runs on an iterative shift-add multiplier that processes `MUL_BPC` multiplier bits per cycle and back-pressures the pipeline through `ready_o`. It sits between ID/EX and EX/MEM and is the multi-cycle, width-generic successor of the combinational ALU control path.

## Interface
- `XLEN`, 32: operand/result width; power of two, minimum 8.
- `MUL_BPC`, 1: multiplier bits consumed per cycle; must be 1, 2 or 4 and divide `XLEN`.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: operation request.
- `ALUOp_i` in 2: 00 load/store, 01 I-type arith, 10 R-type, 11 branch.
- `funct_i` in 10: `{funct7[6:0], funct3[2:0]}`; for I-type, `[9:3]` = imm[11:5].
- `src1_i`, `src2_i` in XLEN: operands (src2 = immediate for I-type).
- `ready_o` out 1: unit can accept a request this cycle.
- `valid_o` out 1: one-cycle pulse, `result_o` valid.
- `result_o` out XLEN: registered result.
- `zero_o` out 1: `result_o == 0`; qualified by `valid_o`.
- `illegal_o` out 1: pulses with `valid_o` on an undecodable funct.

## Operation
- Accept occurs when `valid_i && ready_o` at a rising edge. `valid_i` while `ready_o` = 0 is ignored, not queued.
- Decode for `ALUOp` 10 (exact 10-bit match):
  - 0000000_111 → and; 0000000_110 → or; 0000000_100 → xor.
  - 0000000_000 → add; 0100000_000 → sub.
  - 0000000_001 → sll; 0000000_101 → srl; 0100000_101 → sra.
  - 0000000_010 → slt (signed); 0000001_000 → mul.
  - Anything else → illegal.
- Decode for `ALUOp` 01, by funct3:
  - 000 addi; 111 andi; 110 ori; 100 xori; 010 slti.
  - 001 slli.
  - 101 with `funct_i[8]`: 0 = srli, 1 = srai.
  - Other funct3 values → illegal.
- `ALUOp` 00 → add. `ALUOp` 11 → sub.
- Shift amount = `src2_i[$clog2(XLEN)-1:0]`; higher bits ignored.
- Add, sub and mul wrap modulo 2^XLEN. slt yields 1 or 0, zero-extended.
- Illegal: `result_o` = 0, `illegal_o` = 1 and `valid_o` = 1 with the normal single-cycle latency.
- mul is unsigned shift-add and returns the low XLEN bits of the product (identical for signed operands).
  - On accept: acc = 0, mcand = `src1_i`, mplier = `src2_i`, counter = `XLEN/MUL_BPC`.
  - Each MUL cycle: acc += mcand × mplier[MUL_BPC-1:0]; mcand <<= MUL_BPC; mplier >>= MUL_BPC; counter decrements.
  - No early termination.
- State machine:
  - IDLE: `ready_o` = 1. Accepting mul → MUL. Accepting any other op → stay IDLE; result registered.
  - MUL: `ready_o` = 0. When the counter reaches 1, that edge writes `result_o = acc_next`, pulses `valid_o` and returns to IDLE.
- Reset values: state IDLE, `ready_o` = 1, `valid_o` = 0, `result_o` = 0, `zero_o` = 1, `illegal_o` = 0, internal registers 0.
- Reset mid-MUL: the operation is discarded and no `valid_o` is produced. The unit is in IDLE with `ready_o` = 1 in the cycle after the reset edge.
- Reset has priority over accept on the same edge.

## Timing
- Single-cycle op accepted at edge T: `valid_o` = 1 and `result_o` valid during the cycle after T; `valid_o` deasserts after edge T+1 unless a new op is accepted at edge T+1. Back-to-back accepts give one result per cycle.
- mul accepted at edge T:
  - `ready_o` = 0 for N = `XLEN/MUL_BPC` cycles (after edges T … T+N-1).
  - Result valid after edge T+N, with `valid_o` = 1 and `ready_o` = 1 in that same cycle.
  - A new request may be accepted at edge T+N+1.
- `result_o` and `zero_o` hold their last values while `valid_o` = 0.
- `ready_o` is a function of state only, with no combinational path from `valid_i`.

## Test plan
- Reset: hold `rst_i` = 1 for 2 cycles with `valid_i` = 1 → `ready_o` = 1, `valid_o` = 0, `result_o` = 0, `zero_o` = 1.
- R-type stream, one op per cycle:
  - add 5+7 → 0x0000000C.
  - sub 5-7 → 0xFFFFFFFE.
  - slt 0xFFFFFFFF,1 → 1.
  - sll 1 by 35 → 0x00000008.
  - `valid_o` high on 4 consecutive cycles, each result one cycle after its accept.
- I-type shifts: `src1_i` = 0x80000000, `src2_i` = 4.
  - funct 0100000_101 (srai) → 0xF8000000.
  - funct 0000000_101 (srli) → 0x08000000.
- mul 0xFFFFFFFF × 3 with XLEN=32, MUL_BPC=1 → `ready_o` low exactly 32 cycles, then 0xFFFFFFFD with `valid_o`. An add request issued during busy produces no result. Repeat with MUL_BPC=4 → 8 cycles, same result.
- Assert `rst_i` 10 cycles into a mul → no `valid_o` ever; `ready_o` = 1 in the next cycle; a following add 1+1 returns 2.
- ALUOp 10, funct 1111111_000 → `illegal_o` = 1, `result_o` = 0 one cycle later. ALUOp 11 with equal operands 0x1234 → `zero_o` = 1, `result_o` = 0, `illegal_o` = 0.
